// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg -- shared definitions for the pipelined adder (pipe_adder).
//
// Contents:
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   stage_reg_t            : layout of one pipeline stage register at the
//                            default width (valid, carry, partial sum and the
//                            operands still travelling down the pipe).
//                            adder_stage builds the same layout at its own
//                            parameterised width.
//   geometry_ok()          : legality check for a WIDTH/STAGES pair
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_STAGES = 2;

   typedef struct packed {
      logic                 valid;
      logic                 carry;
      logic [DEF_WIDTH-1:0] psum;
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
   } stage_reg_t;

   // Width must split evenly into 1..8 chunks and be at least 2 bits.
   function automatic bit geometry_ok(input int width, input int stages);
      return (width >= 2) && (stages >= 1) && (stages <= 8) &&
             ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_stage.sv
// -----------------------------------------------------------------------------
// adder_stage -- one registered slice of the pipelined adder.
//
// Adds the CHUNK-bit slice starting at bit INDEX*CHUNK of the operands plus
// the incoming carry, merges the slice result into the partial sum and
// registers everything (valid, carry, partial sum, operands) on en.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en                         advance enable; register holds when low
//   prev_valid/carry/psum/a/b  state from the previous stage (or the inputs)
//   stage_valid/carry/psum/a/b registered state of this stage
//
// SAT = 1 (only used on the last stage) forces the partial sum to all-ones
// when this stage's carry out is set; the carry itself stays raw.
// -----------------------------------------------------------------------------
module adder_stage
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_WIDTH / DEF_STAGES,
   parameter int INDEX = 0,
   parameter bit SAT   = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             prev_valid,
   input  logic             prev_carry,
   input  logic [WIDTH-1:0] prev_psum,
   input  logic [WIDTH-1:0] prev_a,
   input  logic [WIDTH-1:0] prev_b,
   output logic             stage_valid,
   output logic             stage_carry,
   output logic [WIDTH-1:0] stage_psum,
   output logic [WIDTH-1:0] stage_a,
   output logic [WIDTH-1:0] stage_b
);

   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   localparam int LSB = INDEX * CHUNK;

   stage_t           stage_reg;
   stage_t           stage_next;
   logic [CHUNK:0]   chunk_sum;
   logic [WIDTH-1:0] merged;
   logic [WIDTH-1:0] result_psum;

   always_comb begin
      chunk_sum = {1'b0, prev_a[LSB +: CHUNK]} + {1'b0, prev_b[LSB +: CHUNK]}
                + {{CHUNK{1'b0}}, prev_carry};
      merged                = prev_psum;
      merged[LSB +: CHUNK]  = chunk_sum[CHUNK-1:0];
   end

   generate
      if (SAT) begin : g_sat
         assign result_psum = chunk_sum[CHUNK] ? {WIDTH{1'b1}} : merged;
      end else begin : g_wrap
         assign result_psum = merged;
      end
   endgenerate

   assign stage_next = '{valid: prev_valid, carry: chunk_sum[CHUNK],
                         psum: result_psum, a: prev_a, b: prev_b};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_reg <= '0;
      end else if (en) begin
         stage_reg <= stage_next;
      end
   end

   assign stage_valid = stage_reg.valid;
   assign stage_carry = stage_reg.carry;
   assign stage_psum  = stage_reg.psum;
   assign stage_a     = stage_reg.a;
   assign stage_b     = stage_reg.b;

endmodule

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder -- STAGES-deep pipelined unsigned adder with valid/ready flow
// control on both sides.
//
// Ports:
//   clk        sole clock (rising edge)
//   rst_n      asynchronous active-low reset
//   a, b, cin  operands and carry in, qualified by in_valid
//   in_valid   input offer;   in_ready: input accepted this cycle
//   sum, cout  registered result (sum mod 2^WIDTH, carry out of MSB)
//   out_valid  result valid;  out_ready: consumer takes result this cycle
//
// Each stage adds WIDTH/STAGES bits; the last stage register is the output.
// The whole pipe advances together on en = !out_valid || out_ready, so a
// stalled output freezes every stage and in_ready drops.
//
// Build option: define PIPE_ADDER_SAT_EN to saturate sum to all-ones when the
// final carry is set (cout still reports the raw carry). Default: wrap.
// -----------------------------------------------------------------------------
module pipe_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int CHUNK = WIDTH / STAGES;

`ifdef PIPE_ADDER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   generate
      if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
         $error("pipe_adder: WIDTH must be >=2 and divisible by STAGES (1..8)");
      end
   endgenerate

   logic             en;
   // Index 0 is the input side; index k+1 is the register of stage k.
   logic             valid_pipe [0:STAGES];
   logic             carry_pipe [0:STAGES];
   logic [WIDTH-1:0] psum_pipe  [0:STAGES];
   logic [WIDTH-1:0] a_pipe     [0:STAGES];
   logic [WIDTH-1:0] b_pipe     [0:STAGES];

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // When en is high and in_valid is low, this loads a bubble into stage 0.
   assign valid_pipe[0] = in_valid;
   assign carry_pipe[0] = cin;
   assign psum_pipe[0]  = '0;
   assign a_pipe[0]     = a;
   assign b_pipe[0]     = b;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .INDEX (gi),
            .SAT   (SAT_EN && (gi == STAGES - 1))
         ) u_stage (
            .clk         (clk),
            .rst_n       (rst_n),
            .en          (en),
            .prev_valid  (valid_pipe[gi]),
            .prev_carry  (carry_pipe[gi]),
            .prev_psum   (psum_pipe[gi]),
            .prev_a      (a_pipe[gi]),
            .prev_b      (b_pipe[gi]),
            .stage_valid (valid_pipe[gi+1]),
            .stage_carry (carry_pipe[gi+1]),
            .stage_psum  (psum_pipe[gi+1]),
            .stage_a     (a_pipe[gi+1]),
            .stage_b     (b_pipe[gi+1])
         );
      end
   endgenerate

   assign out_valid = valid_pipe[STAGES];
   assign sum       = psum_pipe[STAGES];
   assign cout      = carry_pipe[STAGES];

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder -- self-checking bench for pipe_adder.
// Instance dut  : WIDTH=4,  STAGES=2 (directed + randomized flow control)
// Instance dut16: WIDTH=16, STAGES=4 (carry ripple + randomized stream)
// Expected results come from plain integer arithmetic kept in FIFO order.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

   localparam int W   = 4;
   localparam int S   = 2;
   localparam int W16 = 16;
   localparam int S16 = 4;

`ifdef PIPE_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [W-1:0]  a, b, sum;
   logic          cin, in_valid, in_ready, out_valid, out_ready, cout;
   logic [W16-1:0] a16, b16, sum16;
   logic          cin16, in_valid16, in_ready16, out_valid16, out_ready16, cout16;

   pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
      .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   pipe_adder #(.WIDTH(W16), .STAGES(S16)) dut16 (
      .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
      .in_valid(in_valid16), .in_ready(in_ready16), .sum(sum16), .cout(cout16),
      .out_valid(out_valid16), .out_ready(out_ready16)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: (x + y + c) as carry<<wd | sum, with optional saturation.
   function automatic int ref_add(input int x, input int y, input int c, input int wd);
      int m    = 1 << wd;
      int full = x + y + c;
      int s    = full % m;
      if (SAT && full >= m) s = m - 1;
      return ((full >= m) ? m : 0) + s;
   endfunction

   // ---------------- 4-bit instance bookkeeping ----------------
   int         exp_q[$];
   int         pop_count = 0;
   bit         tx_pend = 1'b0;
   logic [3:0] tx_a = '0, tx_b = '0;
   logic       tx_c = 1'b0;
   bit         hold_pend = 1'b0;
   logic [3:0] hold_sum;
   logic       hold_cout;

   task automatic offer(input logic [3:0] x, input logic [3:0] y, input logic c);
      tx_pend = 1'b1; tx_a = x; tx_b = y; tx_c = c;
   endtask

   // One clock cycle: drive at negedge, evaluate just after, then wait.
   task automatic step(input logic ordy);
      int e;
      in_valid  = tx_pend;
      a         = tx_a;
      b         = tx_b;
      cin       = tx_c;
      out_ready = ordy;
      #1;
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (hold_pend) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_sum", sum, hold_sum);
         chk("hold_cout", cout, hold_cout);
      end
      hold_pend = out_valid && !out_ready;
      hold_sum  = sum;
      hold_cout = cout;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", out_valid, 1'b0);
         end else if (out_ready) begin
            e = exp_q.pop_front();
            chk("sum", sum, e & 15);
            chk("cout", cout, (e >> 4) & 1);
            pop_count++;
            $display("[%0t] w4 result sum=%h cout=%b", $time, sum, cout);
         end
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(ref_add(tx_a, tx_b, tx_c, W));
         tx_pend = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || tx_pend) && n < 60) begin
         step(1'b1);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   // ---------------- 16-bit instance bookkeeping ----------------
   int q16[$];

   task automatic step16(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic ordy);
      int e;
      in_valid16 = v; a16 = x; b16 = y; cin16 = c; out_ready16 = ordy;
      #1;
      if (out_valid16) begin
         if (q16.size() == 0) begin
            chk("w16_spurious", out_valid16, 1'b0);
         end else if (out_ready16) begin
            e = q16.pop_front();
            chk("w16_sum", sum16, e & 32'hFFFF);
            chk("w16_cout", cout16, (e >> 16) & 1);
            $display("[%0t] w16 result sum=%h cout=%b", $time, sum16, cout16);
         end
      end
      if (in_valid16 && in_ready16) q16.push_back(ref_add(x, y, c, W16));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int p0, n;
      rst_n = 1'b1;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
      in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      // reset state
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 4'h0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid16", out_valid16, 1'b0);
      rst_n = 1'b1;
      #1 chk("post_rst_in_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("post_rst_out_valid", out_valid, 1'b0);

      // single op, latency: valid after transfer edge + 1
      offer(4'b0011, 4'b1000, 1'b0);
      step(1'b1);
      chk("lat_edge1_valid", out_valid, 1'b0);
      step(1'b1);
      chk("lat_edge2_valid", out_valid, 1'b1);
      chk("single_sum", sum, 4'b1011);
      chk("single_cout", cout, 1'b0);
      drain();

      // back-to-back, one result per cycle
      offer(4'b0001, 4'b0100, 1'b0); step(1'b1);
      offer(4'b0101, 4'b1000, 1'b0); step(1'b1);
      chk("b2b_valid1", out_valid, 1'b1);
      offer(4'b1111, 4'b0001, 1'b0); step(1'b1);
      chk("b2b_valid2", out_valid, 1'b1);
      step(1'b1);
      chk("b2b_valid3", out_valid, 1'b1);
      chk("b2b_sum3", sum, SAT ? 4'b1111 : 4'b0000);
      chk("b2b_cout3", cout, 1'b1);
      drain();

      // output stall with 3 operations offered
      p0 = pop_count;
      offer(4'd2, 4'd3, 1'b0); step(1'b0);
      offer(4'd4, 4'd5, 1'b1); step(1'b0);
      offer(4'd6, 4'd7, 1'b0);
      repeat (5) step(1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      drain();
      chk("stall_delivered", pop_count - p0, 3);

      // reset with operations in flight
      offer(4'd9, 4'd9, 1'b0); step(1'b1);
      offer(4'd1, 4'd2, 1'b1); step(1'b1);
      chk("pre_rst_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", out_valid, 1'b0);
      chk("async_rst_sum", sum, 4'h0);
      chk("async_rst_cout", cout, 1'b0);
      chk("async_rst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      tx_pend = 1'b0;
      hold_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) step(1'b1);
      chk("post_flush_valid", out_valid, 1'b0);

      // randomized traffic and back-pressure
      for (int i = 0; i < 300; i++) begin
         if (!tx_pend && $urandom_range(0, 3) != 0)
            offer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         step($urandom_range(0, 3) != 0);
      end
      drain();

      // 16-bit, 4 stages: carry ripples through every stage
      step16(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
      for (int e = 1; e <= 3; e++) begin
         chk($sformatf("w16_lat_edge%0d", e), out_valid16, 1'b0);
         step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      end
      chk("w16_lat_edge4", out_valid16, 1'b1);
      chk("w16_ripple_sum", sum16, SAT ? 16'hFFFF : 16'h0000);
      chk("w16_ripple_cout", cout16, 1'b1);
      step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

      for (int i = 0; i < 80; i++)
         step16(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      n = 0;
      while (q16.size() != 0 && n < 40) begin
         step16(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
         n++;
      end
      chk("w16_drain_left", q16.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
